// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display scheduler.
//   - Digit and word geometry of the 8-digit BCD display driver.
//   - Blank codes (any nibble above 9 is dark in the driver; 0xF is used).
//   - Scheduler state encoding.
package disp_pkg;

  localparam int DIGITS  = 8;
  localparam int DIGIT_W = 4;
  localparam int WORD_W  = DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
  localparam logic [WORD_W-1:0]  BLANK_WORD  = {DIGITS{BLANK_DIGIT}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/display_scheduler_tick_gen.sv
// tick_gen: tick prescaler for the display scheduler.
//   Counts 0..TICK_DIV-1 and flags tick during the last count, so one tick
//   is seen every TICK_DIV cycles. restart forces the count back to 0, which
//   lets the scheduler start each interval on an exact tick boundary.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   restart  in   clear the count on the next edge
//   tick     out  high for one cycle at the end of every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: time-shares the 8-digit display between a background
// word and NREQ message requesters, granted round-robin.
//
// state | meaning
// IDLE  | background shown, looking for a request to grant
// SHOW  | granted message shown until hold expires or abort
// GAP   | background shown for one tick before the next grant
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   base_digits  in   background word, nibble 7 leftmost
//   req          in   level request per requester
//   req_digits   in   message word per requester (32 bits each)
//   req_hold     in   display time in ticks per requester (HOLD_W each)
//   abort        in   end the message currently shown
//   gnt          out  one-cycle one-hot grant pulse
//   done         out  one-cycle pulse to the owner when its message ends
//   busy         out  high in SHOW and GAP
//   digits_out   out  word to the display driver
//
// Optional build macro DISP_SCHED_BLINK_EN: blanks the message while the
// remaining hold is 3 or 1 ticks, giving an end-of-message blink.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int TICK_DIV = 100000,
  parameter int HOLD_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W-1:0]        base_digits,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   req_digits,
  input  logic [NREQ*HOLD_W-1:0]   req_hold,
  input  logic                     abort,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [WORD_W-1:0]        digits_out
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WORD_W-1:0]   msg_q, msg_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                busy_q, busy_d;
  logic [WORD_W-1:0]   digits_q, digits_d;

  logic                found;
  logic [PTR_W-1:0]    gidx;
  logic                tick;
  logic                restart;

  // Prescaler restarts whenever SHOW or GAP is entered so each interval
  // is a whole number of ticks long.
  assign restart = (state_d != state_q) && ((state_d == SHOW) || (state_d == GAP));

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        // abort wins over a coincident expiry; both lead to the same GAP
        if (abort) begin
          state_d = GAP;
        end else if (tick && (hold_cnt_q == HOLD_W'(1))) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; outputs are computed from the next state so the
  // registered values line up with the state they describe.
  always_comb begin
    int                gsel;
    logic [HOLD_W-1:0] hold_sel;
    gnt_d      = '0;
    done_d     = '0;
    msg_d      = msg_q;
    hold_cnt_d = hold_cnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    gsel       = int'(gidx);
    hold_sel   = req_hold[HOLD_W*gsel +: HOLD_W];

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[gidx] = 1'b1;
          msg_d       = req_digits[WORD_W*gsel +: WORD_W];
          hold_cnt_d  = (hold_sel == '0) ? HOLD_W'(1) : hold_sel;
          owner_d     = gidx;
          if (gsel == NREQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gidx + PTR_W'(1);
          end
        end
      end
      SHOW: begin
        if (state_d == GAP) begin
          done_d[owner_q] = 1'b1;
        end else if (tick) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);

    if (state_d == SHOW) begin
      digits_d = msg_d;
`ifdef DISP_SCHED_BLINK_EN
      if ((hold_cnt_d <= HOLD_W'(4)) && hold_cnt_d[0]) begin
        digits_d = BLANK_WORD;
      end
`endif
    end else begin
      digits_d = base_digits;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      msg_q      <= BLANK_WORD;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      digits_q   <= BLANK_WORD;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      msg_q      <= msg_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      digits_q   <= digits_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign digits_out = digits_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with TICK_DIV=4, NREQ=2.
module tb_display_scheduler;

  localparam int NREQ     = 2;
  localparam int TICK_DIV = 4;
  localparam int HOLD_W   = 12;

  logic                   clk;
  logic                   rst;
  logic [31:0]            base_digits;
  logic [NREQ-1:0]        req;
  logic [NREQ*32-1:0]     req_digits;
  logic [NREQ*HOLD_W-1:0] req_hold;
  logic                   abort;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   busy;
  logic [31:0]            digits_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  display_scheduler #(
    .NREQ     (NREQ),
    .TICK_DIV (TICK_DIV),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .base_digits (base_digits),
    .req         (req),
    .req_digits  (req_digits),
    .req_hold    (req_hold),
    .abort       (abort),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .digits_out  (digits_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    base_digits = 32'h0000_1234;
    req = '0; req_digits = '0; req_hold = '0; abort = 1'b0;
    repeat (3) step();
    n_checks++;
    if (digits_out !== 32'hFFFF_FFFF) $display("FAIL reset_digits: got %h expected %h", digits_out, 32'hFFFF_FFFF);
    else n_pass++;
    n_checks++;
    if ({gnt, done, busy} !== 5'b0) $display("FAIL reset_flags: got gnt=%b done=%b busy=%b expected all 0", gnt, done, busy);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (digits_out !== 32'h0000_1234) $display("FAIL post_reset_digits: got %h expected %h", digits_out, 32'h0000_1234);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_base_track();
    base_digits = 32'h0000_5678;
    step();
    n_checks++;
    if (digits_out !== 32'h0000_5678) $display("FAIL base_track: got %h expected %h", digits_out, 32'h0000_5678);
    else n_pass++;
    base_digits = 32'h0000_1234;
    step();
  endtask

  // Shows one message from requester 0 and measures SHOW and GAP lengths.
  task automatic run_single(input string name, input logic [31:0] msg,
                            input logic [HOLD_W-1:0] hold, input int exp_show);
    int show_cnt;
    int gap_cnt;
    int extra_done;
    req_digits[31:0] = msg;
    req_hold[HOLD_W-1:0] = hold;
    req = 2'b01;
    step();
    req = 2'b00;
    n_checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 || digits_out !== msg)
      $display("FAIL %s_grant: got gnt=%b busy=%b digits=%h expected gnt=01 busy=1 digits=%h", name, gnt, busy, digits_out, msg);
    else n_pass++;
    show_cnt = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (digits_out !== msg) break;
      show_cnt++;
    end
    n_checks++;
    if (show_cnt != exp_show) $display("FAIL %s_show_len: got %0d cycles expected %0d", name, show_cnt, exp_show);
    else n_pass++;
    n_checks++;
    if (done !== 2'b01 || busy !== 1'b1 || digits_out !== base_digits)
      $display("FAIL %s_gap_entry: got done=%b busy=%b digits=%h expected done=01 busy=1 digits=%h", name, done, busy, digits_out, base_digits);
    else n_pass++;
    gap_cnt = 1;
    extra_done = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done !== 2'b00) extra_done++;
      if (busy !== 1'b1) break;
      gap_cnt++;
    end
    n_checks++;
    if (gap_cnt != TICK_DIV || extra_done != 0)
      $display("FAIL %s_gap_len: got %0d cycles, %0d extra done expected %0d cycles, 0 extra done", name, gap_cnt, extra_done, TICK_DIV);
    else n_pass++;
  endtask

  task automatic test_single();
    run_single("single", 32'hFFFF_0AB1, 12'd3, 3 * TICK_DIV);
  endtask

  task automatic test_hold_zero();
    run_single("hold0", 32'h0000_0777, 12'd0, TICK_DIV);
  endtask

  // Both requests held from reset: grants alternate, and consecutive grant
  // pulses are hold*4 + 5 cycles apart (hold*4 + 4 cycles lie between them).
  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4];
    logic [31:0] exp_dig [4];
    int          exp_gap [4];
    logic [1:0]  got_gnt [4];
    logic [31:0] got_dig [4];
    int          got_cyc [4];
    int          n;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_dig = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0111, 32'h0000_0222};
    exp_gap = '{0, 2 * 4 + 5, 1 * 4 + 5, 2 * 4 + 5};
    rst = 1'b1;
    req_digits = {32'h0000_0222, 32'h0000_0111};
    req_hold   = {12'd1, 12'd2};
    req = 2'b11;
    step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      step();
      if (gnt !== 2'b00) begin
        got_gnt[n] = gnt;
        got_dig[n] = digits_out;
        got_cyc[n] = cyc;
        n++;
      end
    end
    req = 2'b00;
    n_checks++;
    if (n != 4) $display("FAIL rr_count: got %0d grants expected 4", n);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (got_gnt[k] !== exp_gnt[k] || got_dig[k] !== exp_dig[k])
        $display("FAIL rr_grant%0d: got gnt=%b digits=%h expected gnt=%b digits=%h", k, got_gnt[k], got_dig[k], exp_gnt[k], exp_dig[k]);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (got_cyc[k] - got_cyc[k-1] != exp_gap[k])
          $display("FAIL rr_spacing%0d: got %0d cycles expected %0d", k, got_cyc[k] - got_cyc[k-1], exp_gap[k]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
    step();
  endtask

  // Grants requester 0, raises abort in SHOW cycle abort_at (0-based), and
  // checks one done pulse, the GAP length and that SHOW lasted abort_at+1.
  task automatic run_abort(input string name, input logic [HOLD_W-1:0] hold, input int abort_at);
    int show_cnt;
    int gap_cnt;
    int extra_done;
    req_digits[31:0] = 32'h0000_0ABC;
    req_hold[HOLD_W-1:0] = hold;
    req = 2'b01;
    step();
    req = 2'b00;
    show_cnt = (digits_out === 32'h0000_0ABC) ? 1 : 0;
    for (int i = 0; i < abort_at; i++) begin
      step();
      if (digits_out === 32'h0000_0ABC) show_cnt++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (show_cnt != abort_at + 1) $display("FAIL %s_show_len: got %0d cycles expected %0d", name, show_cnt, abort_at + 1);
    else n_pass++;
    n_checks++;
    if (done !== 2'b01 || busy !== 1'b1 || digits_out !== base_digits)
      $display("FAIL %s_done: got done=%b busy=%b digits=%h expected done=01 busy=1 digits=%h", name, done, busy, digits_out, base_digits);
    else n_pass++;
    gap_cnt = 1;
    extra_done = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done !== 2'b00) extra_done++;
      if (busy !== 1'b1) break;
      gap_cnt++;
    end
    n_checks++;
    if (gap_cnt != TICK_DIV || extra_done != 0)
      $display("FAIL %s_gap: got %0d cycles, %0d extra done expected %0d cycles, 0 extra done", name, gap_cnt, extra_done, TICK_DIV);
    else n_pass++;
  endtask

  task automatic test_abort();
    run_abort("abort", 12'd10, 5);
    // hold=1: SHOW cycle 3 is also the expiry tick
    run_abort("abort_tick", 12'd1, TICK_DIV - 1);
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 2'b00 || digits_out !== base_digits)
      $display("FAIL abort_idle: got busy=%b done=%b digits=%h expected busy=0 done=00 digits=%h", busy, done, digits_out, base_digits);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [31:0] exp;
    int          wrong;
    req_digits[31:0] = 32'h0000_0321;
    req_hold[HOLD_W-1:0] = 12'd6;
    req = 2'b01;
    wrong = 0;
    for (int c = 0; c < 6 * TICK_DIV; c++) begin
      step();
      req = 2'b00;
      exp = 32'h0000_0321;
`ifdef DISP_SCHED_BLINK_EN
      if ((c >= 12 && c <= 15) || (c >= 20 && c <= 23)) exp = 32'hFFFF_FFFF;
`endif
      if (digits_out !== exp) wrong++;
    end
    n_checks++;
    if (wrong != 0) $display("FAIL blink_pattern: got %0d wrong SHOW cycles expected 0", wrong);
    else n_pass++;
    step();
    n_checks++;
    if (done !== 2'b01) $display("FAIL blink_done: got %b expected 01", done);
    else n_pass++;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) step();
  endtask

  initial begin
    test_reset();
    test_base_track();
    test_single();
    test_hold_zero();
    test_abort_idle();
    test_abort();
    test_blink();
    test_round_robin();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the 8-digit BCD display driver between a background source (score/timer) and NREQ message requesters (e.g. "HIT", "MISS", level banners).
- A requester raises req with a packed 8-digit word and a hold time in ticks. The scheduler grants round-robin, shows the message for exactly the hold time, then reverts to the background for one gap tick.
- Output feeds the display driver's eight 4-bit digit inputs directly: nibble 7 goes to display7, the leftmost digit.

Parameters:
- NREQ, 2, number of message requesters (1..8).
- TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz); minimum 2.
- HOLD_W, 12, width of each per-request hold field, in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- base_digits  in  32  background digits, nibble 7 leftmost; sampled every cycle.
- req  in  NREQ  level request per requester.
- req_digits  in  NREQ*32  message word, requester i at bits [32i+31:32i].
- req_hold  in  NREQ*HOLD_W  display time in ticks, requester i at bits [HOLD_W*i+HOLD_W-1:HOLD_W*i].
- abort  in  1  terminates the message currently shown.
- gnt  out  NREQ  one-cycle grant pulse, one-hot.
- done  out  NREQ  one-cycle pulse to the owner when its message ends (expiry or abort).
- busy  out  1  high in SHOW and GAP.
- digits_out  out  32  digits to the display driver.

Behaviour:
- All outputs are registered.
- Reset values:
  - digits_out = 32'hFFFF_FFFF (every digit blank; codes >9 blank in the driver).
  - gnt = 0, done = 0, busy = 0.
  - state = IDLE, rr_ptr = 0, prescaler = 0, hold_cnt = 0.
- Reset mid-operation abandons any message. No done pulse is issued.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits an internal tick when wrapping.
  - Forced to 0 on entry to SHOW and on entry to GAP, so both intervals are tick-exact.
- IDLE:
  - digits_out <= base_digits.
  - If any req bit is high, grant the first set bit searching upward from rr_ptr, wrapping.
  - Latch that requester's digits and hold. Hold of 0 is treated as 1.
  - Set rr_ptr <= (granted+1) mod NREQ and go to SHOW.
- Grant latency: gnt[i], busy=1 and message digits_out all appear one cycle after req is first sampled high.
- Requester handshake: the requester deasserts req on the cycle gnt is seen. A req still high in a later IDLE cycle is a new request. A req dropped before grant is silently ignored.
- SHOW:
  - digits_out <= latched message.
  - On each tick: if hold_cnt == 1, pulse done[owner] and go to GAP; otherwise decrement hold_cnt.
  - Message is visible for exactly max(H,1)*TICK_DIV cycles.
- abort:
  - Effective in SHOW only; ignored in IDLE and GAP.
  - Next cycle: done[owner] pulses and the state goes to GAP.
  - abort has priority over a coincident tick expiry; only one done pulse is issued.
- GAP:
  - digits_out <= base_digits for exactly TICK_DIV cycles; requests are not granted.
  - Then go to IDLE with busy = 0. A pending req is granted on the first IDLE cycle.
- A req arriving during SHOW or GAP waits; it is not lost if held.
- base_digits changes are tracked with one-cycle latency in IDLE and GAP.

Optional Feature:
- Macro: DISP_SCHED_BLINK_EN.
- With the macro defined: while in SHOW with hold_cnt ≤ 4 and hold_cnt odd, digits_out is 32'hFFFF_FFFF (blank). This gives an end-of-message blink. Timing, gnt and done are unchanged.
- Without the macro: the message is shown steadily for the whole hold.

Decomposition:
- Package disp_pkg holds:
  - BLANK_DIGIT = 4'hF and BLANK_WORD = 32'hFFFF_FFFF.
  - The state typedef {IDLE, SHOW, GAP}.
  - DIGITS = 8.
- Sub-module tick_gen: prescaler with a restart input and a tick output, parameter TICK_DIV.
- Round-robin search and FSM stay in display_scheduler.

Test Plan (TICK_DIV=4, NREQ=2):
- Reset with base_digits=32'h0000_1234 held → digits_out=FFFFFFFF during rst; first cycle after rst falls, digits_out=00001234, busy=0.
- req0 pulsed with digits 32'hFFFF_0AB1, hold=3 → next cycle gnt0=1, busy=1. Message shown exactly 12 cycles, done0 pulses on the first GAP cycle. Base shown 4 cycles, then busy=0.
- req0 and req1 held high continuously from reset → grant order 0,1,0,1. Consecutive grants are separated by exactly hold*4+4 cycles.
- hold=10, abort asserted 5 cycles into SHOW → done pulses the following cycle, 4-cycle GAP, no second done. Abort pulsed in IDLE → no effect.
- hold=0 → message shown exactly 4 cycles (treated as 1).
- DISP_SCHED_BLINK_EN, hold=6 → message visible for hold_cnt 6,5,4,2; blank for hold_cnt 3 and 1 (cycles 12–15 and 20–23 of SHOW). Without the macro there is no blank cycle.
